// File: rtl/pc_nzp_unit_pkg.sv
// pc_nzp_unit_pkg
// Shared encodings for the per-thread PC / NZP unit and its return stack:
// core phase codes, next-PC operation codes, NZP flag bit positions and the
// return-stack geometry. Also provides the branch-condition helper.
package pc_nzp_unit_pkg;

    // Core phases this unit reacts to; every other phase holds all state.
    localparam logic [2:0] CORE_EXECUTE = 3'b101;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;

    // Next-PC operation selected by the decoder.
    typedef enum logic [1:0] {
        PC_SEQ   = 2'b00,
        PC_BRNZP = 2'b01,
        PC_CALL  = 2'b10,
        PC_RET   = 2'b11
    } pc_mux_e;

    // Bit positions inside the {N,Z,P} flag vector.
    localparam int NZP_N = 2;
    localparam int NZP_Z = 1;
    localparam int NZP_P = 0;

    // Return stack geometry: 4 entries, occupancy counter must reach 4.
    localparam int RETURN_STACK_DEPTH = 4;
    localparam int STACK_PTR_W        = 3;
    localparam int STACK_IDX_W        = 2;

    // A branch is taken when any flag selected by the mask is currently set.
    function automatic logic branch_taken(input logic [2:0] flags,
                                          input logic [2:0] mask);
        return (flags[NZP_N] & mask[NZP_N]) |
               (flags[NZP_Z] & mask[NZP_Z]) |
               (flags[NZP_P] & mask[NZP_P]);
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// pc_return_stack
// Four-entry LIFO of 8-bit return addresses with an occupancy counter.
// Push is ignored when full and pop is ignored when empty, so the caller
// only needs to look at full_o / empty_o to decide on error reporting.
// Entries are never cleared; a reset only discards them via the counter.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high; clears occupancy
//   enable_i     all state holds while low
//   push_i       push push_data_i (when not full)
//   pop_i        pop the top entry (when not empty)
//   push_data_i  return address to push
//   top_o        current top entry (valid when not empty)
//   depth_o      occupancy, 0..4
//   full_o       occupancy == 4
//   empty_o      occupancy == 0
module pc_return_stack
    import pc_nzp_unit_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [7:0]             push_data_i,
    output logic [7:0]             top_o,
    output logic [STACK_PTR_W-1:0] depth_o,
    output logic                   full_o,
    output logic                   empty_o
);

    logic [7:0]             entries_q [RETURN_STACK_DEPTH];
    logic [STACK_PTR_W-1:0] depth_q;
    logic [STACK_PTR_W-1:0] depth_d;
    logic [STACK_IDX_W-1:0] wr_idx;
    logic [STACK_IDX_W-1:0] top_idx;
    logic                   do_push;
    logic                   do_pop;

    assign full_o  = (depth_q == STACK_PTR_W'(RETURN_STACK_DEPTH));
    assign empty_o = (depth_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Low bits of the count address the next free slot; one below it is the
    // top. At depth 4 the low bits wrap to 0 so top_idx correctly becomes 3.
    assign wr_idx  = depth_q[STACK_IDX_W-1:0];
    assign top_idx = depth_q[STACK_IDX_W-1:0] - STACK_IDX_W'(1);
    assign top_o   = entries_q[top_idx];
    assign depth_o = depth_q;

    always_comb begin
        depth_d = depth_q;
        if (do_push) begin
            depth_d = depth_q + STACK_PTR_W'(1);
        end else if (do_pop) begin
            depth_d = depth_q - STACK_PTR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            depth_q <= '0;
        end else if (enable_i) begin
            depth_q <= depth_d;
        end
    end

    // Storage carries no reset; stale entries are unreachable once depth is 0.
    always_ff @(posedge clock) begin
        if (!reset && enable_i && do_push) begin
            entries_q[wr_idx] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_nzp_unit.sv
// pc_nzp_unit
// Per-thread next-PC computation and NZP flag register. In EXECUTE it picks
// the next PC (sequential, conditional branch, call, return) using the
// return stack; in UPDATE it optionally latches the ALU flags. Overflow and
// underflow of the return stack are reported through sticky flags and the
// offending CALL/RET falls through to current_pc + 1.
//
// Ports:
//   clock              rising-edge clock
//   reset              synchronous, active-high, highest priority
//   enable             thread active; every register holds while low
//   core_state         core phase (EXECUTE / UPDATE)
//   pc_mux             next-PC op: SEQ, BRnzp, CALL, RET
//   decoded_nzp        branch condition mask {N,Z,P}
//   decoded_immediate  branch / call target
//   nzp_write_enable   latch alu_nzp in UPDATE
//   alu_nzp            ALU flags {N,Z,P}
//   current_pc         PC of the instruction in flight
//   next_pc            registered next PC
//   nzp_out            registered NZP flags
//   stack_depth        return-stack occupancy 0..4
//   stack_overflow     sticky: CALL attempted with a full stack
//   stack_underflow    sticky: RET attempted with an empty stack
module pc_nzp_unit
    import pc_nzp_unit_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] core_state,
    input  logic [1:0] pc_mux,
    input  logic [2:0] decoded_nzp,
    input  logic [7:0] decoded_immediate,
    input  logic       nzp_write_enable,
    input  logic [2:0] alu_nzp,
    input  logic [7:0] current_pc,
    output logic [7:0] next_pc,
    output logic [2:0] nzp_out,
    output logic [2:0] stack_depth,
    output logic       stack_overflow,
    output logic       stack_underflow
);

    logic [7:0] next_pc_q, next_pc_d;
    logic [2:0] nzp_q, nzp_d;
    logic       ovf_q, ovf_d;
    logic       unf_q, unf_d;
    logic       push, pop;
    logic [7:0] pc_plus1;
    logic [7:0] stack_top;
    logic       stack_full, stack_empty;

    // Wraps 8'hFF to 8'h00; also the return address pushed by CALL.
    assign pc_plus1 = current_pc + 8'd1;

    pc_return_stack u_stack (
        .clock       (clock),
        .reset       (reset),
        .enable_i    (enable),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (pc_plus1),
        .top_o       (stack_top),
        .depth_o     (stack_depth),
        .full_o      (stack_full),
        .empty_o     (stack_empty)
    );

    always_comb begin
        next_pc_d = next_pc_q;
        nzp_d     = nzp_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        push      = 1'b0;
        pop       = 1'b0;

        if (core_state == CORE_EXECUTE) begin
            case (pc_mux_e'(pc_mux))
                PC_SEQ: begin
                    next_pc_d = pc_plus1;
                end
                PC_BRNZP: begin
                    // Uses the flags already registered, so a CMP in the
                    // previous instruction steers this branch.
                    next_pc_d = branch_taken(nzp_q, decoded_nzp) ? decoded_immediate
                                                                  : pc_plus1;
                end
                PC_CALL: begin
                    if (!stack_full) begin
                        push      = 1'b1;
                        next_pc_d = decoded_immediate;
                    end else begin
                        ovf_d     = 1'b1;
                        next_pc_d = pc_plus1;
                    end
                end
                PC_RET: begin
                    if (!stack_empty) begin
                        pop       = 1'b1;
                        next_pc_d = stack_top;
                    end else begin
                        unf_d     = 1'b1;
                        next_pc_d = pc_plus1;
                    end
                end
            endcase
        end

        if (core_state == CORE_UPDATE && nzp_write_enable) begin
            nzp_d = alu_nzp;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            next_pc_q <= 8'h00;
            nzp_q     <= 3'b000;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else if (enable) begin
            next_pc_q <= next_pc_d;
            nzp_q     <= nzp_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign next_pc         = next_pc_q;
    assign nzp_out         = nzp_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule

// File: tb/tb_pc_nzp_unit.sv
module tb_pc_nzp_unit;

    localparam logic [2:0] EXE = 3'b101;
    localparam logic [2:0] UPD = 3'b110;
    localparam logic [2:0] IDL = 3'b000;
    localparam logic [1:0] M_SEQ  = 2'b00;
    localparam logic [1:0] M_BR   = 2'b01;
    localparam logic [1:0] M_CALL = 2'b10;
    localparam logic [1:0] M_RET  = 2'b11;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] core_state = 3'b000;
    logic [1:0] pc_mux = 2'b00;
    logic [2:0] decoded_nzp = 3'b000;
    logic [7:0] decoded_immediate = 8'h00;
    logic       nzp_write_enable = 1'b0;
    logic [2:0] alu_nzp = 3'b000;
    logic [7:0] current_pc = 8'h00;
    logic [7:0] next_pc;
    logic [2:0] nzp_out;
    logic [2:0] stack_depth;
    logic       stack_overflow;
    logic       stack_underflow;

    typedef struct packed {
        logic [7:0] pc;
        logic [2:0] nzp;
        logic [2:0] dep;
        logic       ovf;
        logic       unf;
    } snap_t;

    snap_t exp_q[$];
    snap_t obs_q[$];
    string tag_q[$];
    int    checks   = 0;
    int    failures = 0;

    pc_nzp_unit dut (
        .clock             (clock),
        .reset             (reset),
        .enable            (enable),
        .core_state        (core_state),
        .pc_mux            (pc_mux),
        .decoded_nzp       (decoded_nzp),
        .decoded_immediate (decoded_immediate),
        .nzp_write_enable  (nzp_write_enable),
        .alu_nzp           (alu_nzp),
        .current_pc        (current_pc),
        .next_pc           (next_pc),
        .nzp_out           (nzp_out),
        .stack_depth       (stack_depth),
        .stack_overflow    (stack_overflow),
        .stack_underflow   (stack_underflow)
    );

    always #5 clock = ~clock;

    function automatic snap_t S(input logic [7:0] pc, input logic [2:0] nzp,
                                input logic [2:0] dep, input logic ovf, input logic unf);
        return {pc, nzp, dep, ovf, unf};
    endfunction

    // Drive one cycle, record the expected outcome, capture the DUT outcome.
    task automatic drive(input string tag, input logic rst, input logic en,
                         input logic [2:0] st, input logic [1:0] mux,
                         input logic [2:0] mask, input logic [7:0] imm,
                         input logic we, input logic [2:0] alu,
                         input logic [7:0] pc, input snap_t ex);
        reset = rst; enable = en; core_state = st; pc_mux = mux;
        decoded_nzp = mask; decoded_immediate = imm;
        nzp_write_enable = we; alu_nzp = alu; current_pc = pc;
        exp_q.push_back(ex);
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
        obs_q.push_back({next_pc, nzp_out, stack_depth, stack_overflow, stack_underflow});
    endtask

    task automatic test_reset();
        drive("reset_a", 1, 0, IDL, M_SEQ, 3'b000, 8'h00, 0, 3'b000, 8'h00, S(8'h00, 3'b000, 0, 0, 0));
        drive("reset_b", 1, 1, EXE, M_CALL, 3'b111, 8'hAA, 1, 3'b001, 8'h12, S(8'h00, 3'b000, 0, 0, 0));
        while (exp_q.size() > 0) begin
            snap_t e, o; string t;
            e = exp_q.pop_front(); t = tag_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL %s no output captured", t);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL %s got pc=%h nzp=%b depth=%0d ovf=%b unf=%b required pc=%h nzp=%b depth=%0d ovf=%b unf=%b",
                             t, o.pc, o.nzp, o.dep, o.ovf, o.unf, e.pc, e.nzp, e.dep, e.ovf, e.unf);
                end
            end
        end
    endtask

    task automatic test_seq_wrap();
        drive("rst_seq",   1, 1, IDL, M_SEQ, 3'b000, 8'h00, 0, 3'b000, 8'h00, S(8'h00, 3'b000, 0, 0, 0));
        drive("seq_7f",    0, 1, EXE, M_SEQ, 3'b000, 8'h00, 0, 3'b000, 8'h7F, S(8'h80, 3'b000, 0, 0, 0));
        drive("idle_hold", 0, 1, IDL, M_SEQ, 3'b000, 8'h00, 0, 3'b000, 8'h33, S(8'h80, 3'b000, 0, 0, 0));
        drive("seq_ff",    0, 1, EXE, M_SEQ, 3'b000, 8'h00, 0, 3'b000, 8'hFF, S(8'h00, 3'b000, 0, 0, 0));
        drive("br111_z0",  0, 1, EXE, M_BR,  3'b111, 8'h12, 0, 3'b000, 8'h30, S(8'h31, 3'b000, 0, 0, 0));
        while (exp_q.size() > 0) begin
            snap_t e, o; string t;
            e = exp_q.pop_front(); t = tag_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL %s no output captured", t);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL %s got pc=%h nzp=%b depth=%0d ovf=%b unf=%b required pc=%h nzp=%b depth=%0d ovf=%b unf=%b",
                             t, o.pc, o.nzp, o.dep, o.ovf, o.unf, e.pc, e.nzp, e.dep, e.ovf, e.unf);
                end
            end
        end
    endtask

    task automatic test_branch();
        drive("rst_br",     1, 1, IDL, M_SEQ, 3'b000, 8'h00, 0, 3'b000, 8'h00, S(8'h00, 3'b000, 0, 0, 0));
        drive("seq_41",     0, 1, EXE, M_SEQ, 3'b000, 8'h00, 0, 3'b000, 8'h41, S(8'h42, 3'b000, 0, 0, 0));
        drive("upd_z",      0, 1, UPD, M_SEQ, 3'b000, 8'h00, 1, 3'b010, 8'h99, S(8'h42, 3'b010, 0, 0, 0));
        drive("br_010",     0, 1, EXE, M_BR,  3'b010, 8'h20, 0, 3'b000, 8'h05, S(8'h20, 3'b010, 0, 0, 0));
        drive("br_101",     0, 1, EXE, M_BR,  3'b101, 8'h20, 0, 3'b000, 8'h05, S(8'h06, 3'b010, 0, 0, 0));
        drive("br_000",     0, 1, EXE, M_BR,  3'b000, 8'h20, 0, 3'b000, 8'h07, S(8'h08, 3'b010, 0, 0, 0));
        drive("br_111_we",  0, 1, EXE, M_BR,  3'b111, 8'h55, 1, 3'b100, 8'h09, S(8'h55, 3'b010, 0, 0, 0));
        drive("upd_nowe",   0, 1, UPD, M_SEQ, 3'b000, 8'h00, 0, 3'b001, 8'h00, S(8'h55, 3'b010, 0, 0, 0));
        drive("upd_n",      0, 1, UPD, M_SEQ, 3'b000, 8'h00, 1, 3'b100, 8'h00, S(8'h55, 3'b100, 0, 0, 0));
        drive("br_100",     0, 1, EXE, M_BR,  3'b100, 8'h66, 0, 3'b000, 8'h20, S(8'h66, 3'b100, 0, 0, 0));
        drive("br_011",     0, 1, EXE, M_BR,  3'b011, 8'h77, 0, 3'b000, 8'h21, S(8'h22, 3'b100, 0, 0, 0));
        while (exp_q.size() > 0) begin
            snap_t e, o; string t;
            e = exp_q.pop_front(); t = tag_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL %s no output captured", t);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL %s got pc=%h nzp=%b depth=%0d ovf=%b unf=%b required pc=%h nzp=%b depth=%0d ovf=%b unf=%b",
                             t, o.pc, o.nzp, o.dep, o.ovf, o.unf, e.pc, e.nzp, e.dep, e.ovf, e.unf);
                end
            end
        end
    endtask

    task automatic test_call_ret();
        drive("rst_call",  1, 1, IDL, M_SEQ,  3'b000, 8'h00, 0, 3'b000, 8'h00, S(8'h00, 3'b000, 0, 0, 0));
        drive("call_upd",  0, 1, UPD, M_CALL, 3'b000, 8'h40, 0, 3'b000, 8'h10, S(8'h00, 3'b000, 0, 0, 0));
        drive("call_40",   0, 1, EXE, M_CALL, 3'b000, 8'h40, 0, 3'b000, 8'h10, S(8'h40, 3'b000, 1, 0, 0));
        drive("ret_idle",  0, 1, IDL, M_RET,  3'b000, 8'h00, 0, 3'b000, 8'h45, S(8'h40, 3'b000, 1, 0, 0));
        drive("ret_45",    0, 1, EXE, M_RET,  3'b000, 8'h00, 0, 3'b000, 8'h45, S(8'h11, 3'b000, 0, 0, 0));
        drive("call_ff",   0, 1, EXE, M_CALL, 3'b000, 8'h90, 0, 3'b000, 8'hFF, S(8'h90, 3'b000, 1, 0, 0));
        drive("ret_wrap",  0, 1, EXE, M_RET,  3'b000, 8'h00, 0, 3'b000, 8'h91, S(8'h00, 3'b000, 0, 0, 0));
        while (exp_q.size() > 0) begin
            snap_t e, o; string t;
            e = exp_q.pop_front(); t = tag_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL %s no output captured", t);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL %s got pc=%h nzp=%b depth=%0d ovf=%b unf=%b required pc=%h nzp=%b depth=%0d ovf=%b unf=%b",
                             t, o.pc, o.nzp, o.dep, o.ovf, o.unf, e.pc, e.nzp, e.dep, e.ovf, e.unf);
                end
            end
        end
    endtask

    task automatic test_overflow();
        drive("rst_ovf", 1, 1, IDL, M_SEQ, 3'b000, 8'h00, 0, 3'b000, 8'h00, S(8'h00, 3'b000, 0, 0, 0));
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4)
                drive($sformatf("call_%0d", i), 0, 1, EXE, M_CALL, 3'b000, 8'h80 + 8'(i), 0, 3'b000,
                      8'(i), S(8'h80 + 8'(i), 3'b000, 3'(i), 0, 0));
            else
                drive("call_5_ovf", 0, 1, EXE, M_CALL, 3'b000, 8'h85, 0, 3'b000,
                      8'h05, S(8'h06, 3'b000, 3'd4, 1, 0));
        end
        for (int k = 0; k < 4; k++) begin
            drive($sformatf("ret_%0d", k), 0, 1, EXE, M_RET, 3'b000, 8'h00, 0, 3'b000,
                  8'hC0, S(8'h05 - 8'(k), 3'b000, 3'(3 - k), 1, 0));
        end
        while (exp_q.size() > 0) begin
            snap_t e, o; string t;
            e = exp_q.pop_front(); t = tag_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL %s no output captured", t);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL %s got pc=%h nzp=%b depth=%0d ovf=%b unf=%b required pc=%h nzp=%b depth=%0d ovf=%b unf=%b",
                             t, o.pc, o.nzp, o.dep, o.ovf, o.unf, e.pc, e.nzp, e.dep, e.ovf, e.unf);
                end
            end
        end
    endtask

    task automatic test_underflow_enable();
        drive("rst_unf",   1, 1, IDL, M_SEQ,  3'b000, 8'h00, 0, 3'b000, 8'h00, S(8'h00, 3'b000, 0, 0, 0));
        drive("ret_empty", 0, 1, EXE, M_RET,  3'b000, 8'h00, 0, 3'b000, 8'h30, S(8'h31, 3'b000, 0, 0, 1));
        drive("en0_seq",   0, 0, EXE, M_SEQ,  3'b000, 8'h00, 0, 3'b000, 8'h50, S(8'h31, 3'b000, 0, 0, 1));
        drive("en0_call",  0, 0, EXE, M_CALL, 3'b000, 8'h60, 0, 3'b000, 8'h50, S(8'h31, 3'b000, 0, 0, 1));
        drive("en0_upd",   0, 0, UPD, M_SEQ,  3'b000, 8'h00, 1, 3'b001, 8'h50, S(8'h31, 3'b000, 0, 0, 1));
        drive("call_after",0, 1, EXE, M_CALL, 3'b000, 8'h60, 0, 3'b000, 8'h50, S(8'h60, 3'b000, 1, 0, 1));
        drive("ret_after", 0, 1, EXE, M_RET,  3'b000, 8'h00, 0, 3'b000, 8'h61, S(8'h51, 3'b000, 0, 0, 1));
        while (exp_q.size() > 0) begin
            snap_t e, o; string t;
            e = exp_q.pop_front(); t = tag_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL %s no output captured", t);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL %s got pc=%h nzp=%b depth=%0d ovf=%b unf=%b required pc=%h nzp=%b depth=%0d ovf=%b unf=%b",
                             t, o.pc, o.nzp, o.dep, o.ovf, o.unf, e.pc, e.nzp, e.dep, e.ovf, e.unf);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        drive("rst_mid",  1, 1, IDL, M_SEQ, 3'b000, 8'h00, 0, 3'b000, 8'h00, S(8'h00, 3'b000, 0, 0, 0));
        drive("upd_p",    0, 1, UPD, M_SEQ, 3'b000, 8'h00, 1, 3'b001, 8'h00, S(8'h00, 3'b001, 0, 0, 0));
        drive("ret_unf",  0, 1, EXE, M_RET, 3'b000, 8'h00, 0, 3'b000, 8'h30, S(8'h31, 3'b001, 0, 0, 1));
        for (int i = 1; i <= 4; i++) begin
            drive($sformatf("fill_%0d", i), 0, 1, EXE, M_CALL, 3'b000, 8'hA0, 0, 3'b000,
                  8'(i), S(8'hA0, 3'b001, 3'(i), 0, 1));
        end
        drive("fill_ovf", 0, 1, EXE, M_CALL, 3'b000, 8'hA0, 0, 3'b000, 8'h05, S(8'h06, 3'b001, 4, 1, 1));
        drive("ret_to3",  0, 1, EXE, M_RET,  3'b000, 8'h00, 0, 3'b000, 8'h07, S(8'h05, 3'b001, 3, 1, 1));
        drive("rst_prio", 1, 0, EXE, M_CALL, 3'b111, 8'hEE, 1, 3'b100, 8'h70, S(8'h00, 3'b000, 0, 0, 0));
        drive("ret_post", 0, 1, EXE, M_RET,  3'b000, 8'h00, 0, 3'b000, 8'h70, S(8'h71, 3'b000, 0, 0, 1));
        while (exp_q.size() > 0) begin
            snap_t e, o; string t;
            e = exp_q.pop_front(); t = tag_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL %s no output captured", t);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL %s got pc=%h nzp=%b depth=%0d ovf=%b unf=%b required pc=%h nzp=%b depth=%0d ovf=%b unf=%b",
                             t, o.pc, o.nzp, o.dep, o.ovf, o.unf, e.pc, e.nzp, e.dep, e.ovf, e.unf);
                end
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_seq_wrap();
        test_branch();
        test_call_ret();
        test_overflow();
        test_underflow_enable();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
